trace_mem_ctrl: RTL and testbench

- Memory-side responder for the Tracer word interface.
- Accepts deserialized trace words (store path) into an on-chip ring buffer of TRB_DEPTH words, and answers Tracer load requests (load path) with words for serialization to the FPGA stream.
- Tracks trigger position and post-trigger delay, then raises the delayed trigger the Tracer forwards to the FPGA.
- Sits between Tracer and the host/debug readout logic.

---
 rtl/trace_mem_ctrl_pkg.sv | 22 ++
 rtl/trb_ram.sv | 26 ++
 rtl/trace_mem_ctrl.sv | 170 +++++++++++++++++
 tb/tb_trace_mem_ctrl.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/trace_mem_ctrl_pkg.sv
// Shared types and constants for the trace memory controller and its Tracer-facing logic.
package trace_mem_ctrl_pkg;

  localparam int TRB_WIDTH      = 32;
  localparam int TRB_MAX_TRACES = 4;
  localparam int TRB_DEPTH      = 64;

  typedef enum logic [1:0] {
    trace_mode,
    rw_stream_mode,
    w_stream_mode,
    r_stream_mode
  } trg_mode_t;

  typedef enum logic [1:0] {
    IDLE,
    ARMED,
    POST,
    DONE
  } mem_state_t;

endpackage

// File: rtl/trb_ram.sv
// Simple dual-port trace RAM: synchronous write, registered synchronous read (BRAM-friendly).
module trb_ram #(
  parameter int WIDTH     = 32,
  parameter int DEPTH     = 64,
  parameter int ADDR_BITS = $clog2(DEPTH)
) (
  input  logic                 clk_i,
  input  logic                 we_i,
  input  logic [ADDR_BITS-1:0] waddr_i,
  input  logic [WIDTH-1:0]     wdata_i,
  input  logic                 re_i,
  input  logic [ADDR_BITS-1:0] raddr_i,
  output logic [WIDTH-1:0]     rdata_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
    if (re_i) rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/trace_mem_ctrl.sv
// Memory-side responder for the Tracer word interface: ring buffer store path, load path
// with one-cycle grants, trigger position latch and delayed-trigger generation.
module trace_mem_ctrl
  import trace_mem_ctrl_pkg::*;
#(
  parameter int TRB_WIDTH = trace_mem_ctrl_pkg::TRB_WIDTH,
  parameter int TRB_DEPTH = trace_mem_ctrl_pkg::TRB_DEPTH,
  parameter int ADDR_BITS = $clog2(TRB_DEPTH),
  parameter int POS_BITS  = $clog2(TRB_WIDTH)
) (
  input  logic                 CLK_I,
  input  logic                 RST_I,
  input  trg_mode_t            MODE_I,
  input  logic [ADDR_BITS-1:0] TRG_DELAY_I,
  input  logic [TRB_WIDTH-1:0] DATA_I,
  input  logic                 STORE_I,
  output logic                 STORE_PERM_O,
  input  logic                 LOAD_REQUEST_I,
  output logic                 LOAD_GRANT_O,
  output logic [TRB_WIDTH-1:0] DATA_O,
  input  logic                 TRG_EVENT_I,
  input  logic [POS_BITS-1:0]  EVENT_POS_I,
  output logic                 TRG_DELAYED_O,
  output logic [ADDR_BITS-1:0] EVENT_ADDR_O,
  output logic [POS_BITS-1:0]  EVENT_POS_O,
  output mem_state_t           DBG_STATE_O,
  output logic [ADDR_BITS:0]   DBG_COUNT_O
);

  localparam logic [ADDR_BITS:0] DEPTH_CNT = (ADDR_BITS+1)'(TRB_DEPTH);

  // Handshake: a word is taken on any edge where STORE_I && STORE_PERM_O; a load request
  // sampled high with data available yields LOAD_GRANT_O for exactly the next cycle with
  // DATA_O valid in that cycle; requests seen without data are held pending until served.

  mem_state_t           state_q, state_d;
  logic [ADDR_BITS-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [ADDR_BITS-1:0] post_cnt_q, post_cnt_d;
  logic [ADDR_BITS:0]   count_q, count_d, loads_left_q, loads_left_d;
  logic                 pending_q, pending_d, grant_q, grant_d;
  logic                 trg_delayed_q, trg_delayed_d;
  logic [ADDR_BITS-1:0] event_addr_q;
  logic [POS_BITS-1:0]  event_pos_q;
  logic                 store_perm, store_ok, avail, req_active, trg_latch, done_entry;
  logic [TRB_WIDTH-1:0] rdata;

  always_ff @(posedge CLK_I or posedge RST_I) begin
    if (RST_I) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d    = state_q;
    post_cnt_d = post_cnt_q;
    case (state_q)
      IDLE:  state_d = ARMED;
      ARMED: if (store_ok && TRG_EVENT_I) begin
        post_cnt_d = '0;
        state_d    = (TRG_DELAY_I == '0) ? DONE : POST;
      end
      POST: if (store_ok) begin
        post_cnt_d = post_cnt_q + 1'b1;
        if (post_cnt_d == TRG_DELAY_I) state_d = DONE;
      end
      default: state_d = state_q;
    endcase
  end

  always_comb begin
    store_perm = 1'b0;
    avail      = 1'b0;
    if (state_q != IDLE) begin
      case (MODE_I)
        trace_mode: begin
          store_perm = (state_q == ARMED) || (state_q == POST);
          avail      = (state_q == DONE) && (loads_left_q != '0);
        end
        rw_stream_mode: begin
          store_perm = (count_q != DEPTH_CNT);
          avail      = (count_q != '0);
        end
        w_stream_mode:  store_perm = (count_q != DEPTH_CNT);
        default:        avail      = 1'b1;
      endcase
    end
  end

  assign store_ok   = STORE_I && store_perm;
  assign req_active = pending_q || (LOAD_REQUEST_I && !grant_q);
  assign grant_d    = req_active && avail;
  assign pending_d  = req_active && !avail;
  assign trg_latch  = (state_q == ARMED) && store_ok && TRG_EVENT_I;
  assign done_entry = (state_q != DONE) && (state_d == DONE);
  assign wr_ptr_d   = store_ok ? wr_ptr_q + 1'b1 : wr_ptr_q;

  // Trace readout starts at the oldest word, which is where the next write would have gone.
  always_comb begin
    rd_ptr_d     = grant_d ? rd_ptr_q + 1'b1 : rd_ptr_q;
    loads_left_d = loads_left_q;
    count_d      = count_q;
    if (MODE_I == trace_mode) begin
      if (done_entry) begin
        rd_ptr_d     = wr_ptr_d;
        loads_left_d = DEPTH_CNT;
      end else if (grant_d) begin
        loads_left_d = loads_left_q - 1'b1;
      end
    end
    if (MODE_I == rw_stream_mode || MODE_I == w_stream_mode)
      count_d = count_q + (ADDR_BITS+1)'(store_ok) - (ADDR_BITS+1)'(grant_d);
    case (MODE_I)
      rw_stream_mode: trg_delayed_d = (count_d != '0);
      r_stream_mode:  trg_delayed_d = 1'b1;
      default:        trg_delayed_d = (state_d == DONE);
    endcase
  end

  always_ff @(posedge CLK_I or posedge RST_I) begin
    if (RST_I) begin
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      post_cnt_q    <= '0;
      count_q       <= '0;
      loads_left_q  <= '0;
      pending_q     <= 1'b0;
      grant_q       <= 1'b0;
      trg_delayed_q <= 1'b0;
      event_addr_q  <= '0;
      event_pos_q   <= '0;
    end else begin
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      post_cnt_q    <= post_cnt_d;
      count_q       <= count_d;
      loads_left_q  <= loads_left_d;
      pending_q     <= pending_d;
      grant_q       <= grant_d;
      trg_delayed_q <= trg_delayed_d;
      if (trg_latch) begin
        event_addr_q <= wr_ptr_q;
        event_pos_q  <= EVENT_POS_I;
      end
    end
  end

  trb_ram #(
    .WIDTH     (TRB_WIDTH),
    .DEPTH     (TRB_DEPTH),
    .ADDR_BITS (ADDR_BITS)
  ) u_ram (
    .clk_i   (CLK_I),
    .we_i    (store_ok),
    .waddr_i (wr_ptr_q),
    .wdata_i (DATA_I),
    .re_i    (grant_d),
    .raddr_i (rd_ptr_q),
    .rdata_o (rdata)
  );

  // RAM read register has no reset, so the output is qualified by the grant.
  assign DATA_O        = grant_q ? rdata : '0;
  assign STORE_PERM_O  = store_perm;
  assign LOAD_GRANT_O  = grant_q;
  assign TRG_DELAYED_O = trg_delayed_q;
  assign EVENT_ADDR_O  = event_addr_q;
  assign EVENT_POS_O   = event_pos_q;
  assign DBG_STATE_O   = state_q;
  assign DBG_COUNT_O   = count_q;

endmodule

// File: tb/tb_trace_mem_ctrl.sv
// Directed bench for trace_mem_ctrl: trace capture/readout, stream FIFO modes, trigger and reset.
module tb_trace_mem_ctrl;
  import trace_mem_ctrl_pkg::*;

  localparam int W  = 32;
  localparam int AB = 6;
  localparam int PB = 5;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  trg_mode_t     mode = trace_mode;
  logic [AB-1:0] trg_delay = '0;
  logic [W-1:0]  data_in = '0;
  logic          store = 1'b0;
  logic          store_perm;
  logic          load_req = 1'b0;
  logic          load_grant;
  logic [W-1:0]  data_out;
  logic          trg_event = 1'b0;
  logic [PB-1:0] event_pos_in = '0;
  logic          trg_delayed;
  logic [AB-1:0] event_addr;
  logic [PB-1:0] event_pos;
  mem_state_t    dbg_state;
  logic [AB:0]   dbg_count;

  int n_tests = 0;
  int n_fail  = 0;

  // Clock and reset
  always #5 clk = ~clk;

  trace_mem_ctrl dut (
    .CLK_I          (clk),
    .RST_I          (rst),
    .MODE_I         (mode),
    .TRG_DELAY_I    (trg_delay),
    .DATA_I         (data_in),
    .STORE_I        (store),
    .STORE_PERM_O   (store_perm),
    .LOAD_REQUEST_I (load_req),
    .LOAD_GRANT_O   (load_grant),
    .DATA_O         (data_out),
    .TRG_EVENT_I    (trg_event),
    .EVENT_POS_I    (event_pos_in),
    .TRG_DELAYED_O  (trg_delayed),
    .EVENT_ADDR_O   (event_addr),
    .EVENT_POS_O    (event_pos),
    .DBG_STATE_O    (dbg_state),
    .DBG_COUNT_O    (dbg_count)
  );

  // Scoreboard
  task automatic check_eq(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Driver tasks: all run starting 1 time unit after a rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input trg_mode_t m, input logic [AB-1:0] dly);
    rst       = 1'b1;
    mode      = m;
    trg_delay = dly;
    store     = 1'b0;
    load_req  = 1'b0;
    trg_event = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic do_store(input logic [W-1:0] d, input logic trg, input logic [PB-1:0] pos);
    data_in      = d;
    store        = 1'b1;
    trg_event    = trg;
    event_pos_in = pos;
    tick();
    store     = 1'b0;
    trg_event = 1'b0;
  endtask

  task automatic load_check(input string tag, input logic [W-1:0] exp);
    load_req = 1'b1;
    check_eq({tag, "_pre"}, 32'(load_grant), 32'd0);
    tick();
    load_req = 1'b0;
    check_eq({tag, "_grant"}, 32'(load_grant), 32'd1);
    check_eq({tag, "_data"}, data_out, exp);
    tick();
    check_eq({tag, "_drop"}, 32'(load_grant), 32'd0);
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_perm"}, 32'(store_perm), 32'd0);
    check_eq({tag, "_grant"}, 32'(load_grant), 32'd0);
    check_eq({tag, "_data"}, data_out, 32'd0);
    check_eq({tag, "_trgd"}, 32'(trg_delayed), 32'd0);
    check_eq({tag, "_eaddr"}, 32'(event_addr), 32'd0);
    check_eq({tag, "_epos"}, 32'(event_pos), 32'd0);
    check_eq({tag, "_state"}, 32'(dbg_state), 32'(IDLE));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset values, checked while reset is held
    #1 rst = 1'b1;
    #1 check_all_zero("rst0");

    // Trace mode: 100 stores, trigger on store 70, delay 3
    do_reset(trace_mode, 6'd3);
    check_eq("armed_state", 32'(dbg_state), 32'(ARMED));
    check_eq("armed_perm", 32'(store_perm), 32'd1);
    for (int i = 0; i < 100; i++) begin
      do_store(32'(i), (i == 70), 5'd3);
      if (i == 70) begin
        check_eq("tr_eaddr", 32'(event_addr), 32'd6);
        check_eq("tr_epos", 32'(event_pos), 32'd3);
        check_eq("tr_post", 32'(dbg_state), 32'(POST));
      end
      if (i == 72) begin
        check_eq("tr_perm72", 32'(store_perm), 32'd1);
        check_eq("tr_trgd72", 32'(trg_delayed), 32'd0);
      end
      if (i == 73) begin
        check_eq("tr_perm73", 32'(store_perm), 32'd0);
        check_eq("tr_trgd73", 32'(trg_delayed), 32'd1);
        check_eq("tr_done", 32'(dbg_state), 32'(DONE));
      end
    end
    check_eq("tr_eaddr_end", 32'(event_addr), 32'd6);
    for (int i = 0; i < 64; i++) load_check($sformatf("tr_ld%0d", i), 32'(10 + i));
    load_req = 1'b1;
    tick();
    check_eq("tr_ld65_a", 32'(load_grant), 32'd0);
    tick();
    load_req = 1'b0;
    check_eq("tr_ld65_b", 32'(load_grant), 32'd0);
    tick();
    check_eq("tr_ld65_c", 32'(load_grant), 32'd0);
    check_eq("tr_trgd_sticky", 32'(trg_delayed), 32'd1);

    // Reset in POST, then a fresh trigger with zero delay
    do_reset(trace_mode, 6'd5);
    do_store(32'hA0, 1'b0, 5'd0);
    do_store(32'hA1, 1'b0, 5'd0);
    do_store(32'hA2, 1'b1, 5'd9);
    check_eq("rp_eaddr", 32'(event_addr), 32'd2);
    check_eq("rp_epos", 32'(event_pos), 32'd9);
    do_store(32'hA3, 1'b1, 5'd4);
    check_eq("rp_eaddr_ign", 32'(event_addr), 32'd2);
    check_eq("rp_epos_ign", 32'(event_pos), 32'd9);
    check_eq("rp_state", 32'(dbg_state), 32'(POST));
    #2 rst = 1'b1;
    #1 check_all_zero("rp_async");
    do_reset(trace_mode, 6'd0);
    for (int i = 0; i < 3; i++) do_store(32'(i), 1'b0, 5'd0);
    check_eq("d0_trgd_pre", 32'(trg_delayed), 32'd0);
    do_store(32'hB3, 1'b1, 5'd17);
    check_eq("d0_trgd", 32'(trg_delayed), 32'd1);
    check_eq("d0_epos", 32'(event_pos), 32'd17);
    check_eq("d0_eaddr", 32'(event_addr), 32'd3);
    check_eq("d0_perm", 32'(store_perm), 32'd0);
    check_eq("d0_state", 32'(dbg_state), 32'(DONE));

    // rw_stream fill and drain
    do_reset(rw_stream_mode, 6'd0);
    check_eq("rw_perm0", 32'(store_perm), 32'd1);
    check_eq("rw_trgd0", 32'(trg_delayed), 32'd0);
    for (int i = 0; i < 64; i++) do_store(32'h100 + 32'(i), 1'b0, 5'd0);
    check_eq("rw_full_cnt", 32'(dbg_count), 32'd64);
    check_eq("rw_full_perm", 32'(store_perm), 32'd0);
    check_eq("rw_full_trgd", 32'(trg_delayed), 32'd1);
    do_store(32'hDEAD, 1'b0, 5'd0);
    check_eq("rw_ovf_cnt", 32'(dbg_count), 32'd64);
    for (int i = 0; i < 64; i++) load_check($sformatf("rw_ld%0d", i), 32'h100 + 32'(i));
    check_eq("rw_empty_cnt", 32'(dbg_count), 32'd0);
    check_eq("rw_empty_trgd", 32'(trg_delayed), 32'd0);
    load_req = 1'b1;
    tick();
    load_req = 1'b0;
    check_eq("rw_pend_a", 32'(load_grant), 32'd0);
    tick();
    check_eq("rw_pend_b", 32'(load_grant), 32'd0);
    do_store(32'h555, 1'b0, 5'd0);
    check_eq("rw_pend_c", 32'(load_grant), 32'd0);
    tick();
    check_eq("rw_pend_grant", 32'(load_grant), 32'd1);
    check_eq("rw_pend_data", data_out, 32'h555);
    tick();
    check_eq("rw_pend_drop", 32'(load_grant), 32'd0);
    check_eq("rw_pend_cnt", 32'(dbg_count), 32'd0);

    // rw_stream simultaneous store and grant at count 10
    for (int i = 0; i < 10; i++) do_store(32'h200 + 32'(i), 1'b0, 5'd0);
    check_eq("rw_cnt10", 32'(dbg_count), 32'd10);
    load_req = 1'b1;
    do_store(32'h300, 1'b0, 5'd0);
    load_req = 1'b0;
    check_eq("rw_sim_grant", 32'(load_grant), 32'd1);
    check_eq("rw_sim_data", data_out, 32'h200);
    check_eq("rw_sim_cnt", 32'(dbg_count), 32'd10);
    tick();
    for (int i = 1; i < 10; i++) load_check($sformatf("rw_sim_ld%0d", i), 32'h200 + 32'(i));
    load_check("rw_sim_last", 32'h300);
    check_eq("rw_sim_empty", 32'(dbg_count), 32'd0);

    // w_stream: stores counted, loads never granted
    do_reset(w_stream_mode, 6'd0);
    do_store(32'h11, 1'b0, 5'd0);
    do_store(32'h22, 1'b0, 5'd0);
    check_eq("ws_cnt", 32'(dbg_count), 32'd2);
    load_req = 1'b1;
    tick();
    check_eq("ws_grant_a", 32'(load_grant), 32'd0);
    tick();
    load_req = 1'b0;
    check_eq("ws_grant_b", 32'(load_grant), 32'd0);
    check_eq("ws_trgd", 32'(trg_delayed), 32'd0);

    // r_stream: no store permission, loads always available
    do_reset(r_stream_mode, 6'd0);
    check_eq("rs_perm", 32'(store_perm), 32'd0);
    check_eq("rs_trgd", 32'(trg_delayed), 32'd1);
    load_req = 1'b1;
    tick();
    load_req = 1'b0;
    check_eq("rs_grant", 32'(load_grant), 32'd1);
    tick();
    check_eq("rs_drop", 32'(load_grant), 32'd0);

    // Final report
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
